// File: rtl/bsg_mem_1rw_sync_mask_bit_ram_pkg.sv
// Shared helpers for the generic 1rw sync mask-bit RAM.
// Holds the safe clog2 used to size address ports.
package bsg_mem_1rw_sync_mask_bit_ram_pkg;

    // A one-word memory still needs a one-bit address port.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_bit_ram_if.sv
// Access bus of the 1rw sync mask-bit RAM; master issues accesses, slave returns read data.
interface bsg_mem_1rw_sync_mask_bit_ram_if
    import bsg_mem_1rw_sync_mask_bit_ram_pkg::*;
#(
    parameter int width_p = 8,
    parameter int els_p   = 16
);
    localparam int addr_width_lp = safe_clog2(els_p);

    logic [width_p-1:0]       data_i;
    logic [addr_width_lp-1:0] addr_i;
    logic                     v_i;
    logic [width_p-1:0]       w_mask_i;
    logic                     w_i;
    logic [width_p-1:0]       data_o;

    modport master (
        output data_i, addr_i, v_i, w_mask_i, w_i,
        input  data_o
    );

    modport slave (
        input  data_i, addr_i, v_i, w_mask_i, w_i,
        output data_o
    );

endinterface

// File: rtl/bsg_mem_1rw_sync_mask_bit_ram_array.sv
// Storage array: per-bit masked synchronous write, combinational read mux. Not reset.
module bsg_mem_1rw_sync_mask_bit_ram_array #(
    parameter int width_p       = 8,
    parameter int els_p         = 16,
    parameter int addr_width_lp = 4
) (
    input  logic                     clk_i,
    input  logic                     w_en_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [width_p-1:0]       w_mask_i,
    output logic [width_p-1:0]       data_o
);

    logic [width_p-1:0] mem [els_p];

    always_ff @(posedge clk_i) begin
        if (w_en_i) begin
            mem[addr_i] <= (mem[addr_i] & ~w_mask_i) | (data_i & w_mask_i);
        end
    end

    assign data_o = mem[addr_i];

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_bit_ram.sv
// Generic single-port sync-read RAM with per-bit write mask and registered read data.
// Optional simulation-only address checker: define BSG_MEM_ADDR_CHECK_EN.
module bsg_mem_1rw_sync_mask_bit_ram
    import bsg_mem_1rw_sync_mask_bit_ram_pkg::*;
#(
    parameter int width_p           = 8,
    parameter int els_p             = 16,
    parameter int latch_last_read_p = 1
) (
    input  logic                             clk_i,
    input  logic                             reset_ni,
    bsg_mem_1rw_sync_mask_bit_ram_if.slave   bus
);

    localparam int addr_width_lp = safe_clog2(els_p);
    localparam logic [addr_width_lp:0] els_lp = (addr_width_lp + 1)'(els_p);

    logic               in_range;
    logic               write_en;
    logic               read_en;
    logic [width_p-1:0] array_data;
    logic [width_p-1:0] data_r;

    // Out-of-range addresses only occur when els_p is not a power of two.
    assign in_range = ({1'b0, bus.addr_i} < els_lp);
    assign write_en = reset_ni & bus.v_i & bus.w_i & in_range;
    assign read_en  = bus.v_i & ~bus.w_i;

    bsg_mem_1rw_sync_mask_bit_ram_array #(
        .width_p       (width_p),
        .els_p         (els_p),
        .addr_width_lp (addr_width_lp)
    ) array (
        .clk_i    (clk_i),
        .w_en_i   (write_en),
        .addr_i   (bus.addr_i),
        .data_i   (bus.data_i),
        .w_mask_i (bus.w_mask_i),
        .data_o   (array_data)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            data_r <= '0;
        end else if (read_en) begin
            data_r <= in_range ? array_data : '0;
        end else if (latch_last_read_p == 0) begin
            data_r <= '0;
        end
    end

    assign bus.data_o = data_r;

`ifdef BSG_MEM_ADDR_CHECK_EN
    initial begin
        $display("%m: width_p=%0d els_p=%0d", width_p, els_p);
    end

    always @(posedge clk_i) begin
        if (bus.v_i && !in_range) begin
            $error("%m: address %0d out of range (els_p=%0d)", bus.addr_i, els_p);
        end
    end
`else
`endif

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_bit_ram.sv
// Self-checking bench: three RAM variants driven in lockstep against a behavioural memory model.
module tb_bsg_mem_1rw_sync_mask_bit_ram;

    logic clk;
    logic reset_ni;

    int vectors     = 0;
    int miscompares = 0;

    // Variant 0: latch, 16 words; 1: zero policy, 16 words; 2: latch, 12 words.
    bsg_mem_1rw_sync_mask_bit_ram_if #(.width_p(8), .els_p(16)) bus_a ();
    bsg_mem_1rw_sync_mask_bit_ram_if #(.width_p(8), .els_p(16)) bus_b ();
    bsg_mem_1rw_sync_mask_bit_ram_if #(.width_p(8), .els_p(12)) bus_c ();

    bsg_mem_1rw_sync_mask_bit_ram #(.width_p(8), .els_p(16), .latch_last_read_p(1)) dut_a (
        .clk_i(clk), .reset_ni(reset_ni), .bus(bus_a.slave));
    bsg_mem_1rw_sync_mask_bit_ram #(.width_p(8), .els_p(16), .latch_last_read_p(0)) dut_b (
        .clk_i(clk), .reset_ni(reset_ni), .bus(bus_b.slave));
    bsg_mem_1rw_sync_mask_bit_ram #(.width_p(8), .els_p(12), .latch_last_read_p(1)) dut_c (
        .clk_i(clk), .reset_ni(reset_ni), .bus(bus_c.slave));

    logic [7:0] mem_m [3][16];
    logic [7:0] exp_m [3];
    int         els_m [3] = '{16, 16, 12};
    bit         latch_m [3] = '{1'b1, 1'b0, 1'b1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "/latch16"}, bus_a.data_o, exp_m[0]);
        checkOutput({tag, "/zero16"},  bus_b.data_o, exp_m[1]);
        checkOutput({tag, "/latch12"}, bus_c.data_o, exp_m[2]);
    endtask

    // Reference behaviour of one clock edge for each variant.
    task automatic modelEdge(input logic rst_n, input logic v, input logic w,
                             input logic [3:0] addr, input logic [7:0] data, input logic [7:0] mask);
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                exp_m[k] = 8'h00;
            end else if (v && !w) begin
                exp_m[k] = (int'(addr) < els_m[k]) ? mem_m[k][addr] : 8'h00;
            end else begin
                if (v && int'(addr) < els_m[k]) begin
                    for (int b = 0; b < 8; b++) begin
                        if (mask[b]) mem_m[k][addr][b] = data[b];
                    end
                end
                if (!latch_m[k]) exp_m[k] = 8'h00;
            end
        end
    endtask

    task automatic applyStimulus(input logic rst_n, input logic v, input logic w,
                                 input logic [3:0] addr, input logic [7:0] data,
                                 input logic [7:0] mask, input string tag);
        @(negedge clk);
        reset_ni = rst_n;
        bus_a.v_i = v; bus_a.w_i = w; bus_a.addr_i = addr; bus_a.data_i = data; bus_a.w_mask_i = mask;
        bus_b.v_i = v; bus_b.w_i = w; bus_b.addr_i = addr; bus_b.data_i = data; bus_b.w_mask_i = mask;
        bus_c.v_i = v; bus_c.w_i = w; bus_c.addr_i = addr; bus_c.data_i = data; bus_c.w_mask_i = mask;
        @(posedge clk);
        #1;
        modelEdge(rst_n, v, w, addr, data, mask);
        checkAll(tag);
    endtask

    task automatic applyRandom(input logic rst_n, input string tag);
        applyStimulus(rst_n, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), tag);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) exp_m[k] = 8'h00;
        reset_ni = 1'b1;
        bus_a.v_i = 1'b0; bus_a.w_i = 1'b0; bus_a.addr_i = '0; bus_a.data_i = '0; bus_a.w_mask_i = '0;
        bus_b.v_i = 1'b0; bus_b.w_i = 1'b0; bus_b.addr_i = '0; bus_b.data_i = '0; bus_b.w_mask_i = '0;
        bus_c.v_i = 1'b0; bus_c.w_i = 1'b0; bus_c.addr_i = '0; bus_c.data_i = '0; bus_c.w_mask_i = '0;
        #1 reset_ni = 1'b0;

        $display("[TB] reset with random inputs");
        for (int i = 0; i < 4; i++) applyRandom(1'b0, "reset_hold");

        $display("[TB] initialise every word");
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b1, 1'b1, 1'b1, 4'(i), 8'((i * 37 + 11) & 255), 8'hFF, "init_write");

        $display("[TB] full write and read");
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd5, 8'hA5, 8'hFF, "full_write");
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd5, 8'h00, 8'h00, "full_read");
        checkOutput("full_read_const", bus_a.data_o, 8'hA5);

        $display("[TB] masked write");
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd5, 8'h0F, 8'h3C, "masked_write");
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd5, 8'h00, 8'h00, "masked_read");
        checkOutput("masked_const", bus_a.data_o, 8'h8D);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd5, 8'hFF, 8'h00, "zero_mask_write");
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd5, 8'h00, 8'h00, "zero_mask_read");

        $display("[TB] latch policy");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 4'd5, 8'hFF, 8'hFF, "policy_idle");
        checkOutput("policy_latch_const", bus_a.data_o, 8'h8D);
        checkOutput("policy_zero_const", bus_b.data_o, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd5, 8'hFF, 8'hFF, "policy_write");
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd5, 8'h00, 8'h00, "policy_read");

        $display("[TB] back-to-back accesses");
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd2, 8'h11, 8'hFF, "b2b_write");
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd2, 8'h00, 8'h00, "b2b_read");
        checkOutput("b2b_const", bus_a.data_o, 8'h11);
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, (i % 2 == 0) ? 4'd5 : 4'd2, 8'h00, 8'h00, "alternate_read");

        $display("[TB] out-of-range address");
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd13, 8'h77, 8'hFF, "oor_write");
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd13, 8'h00, 8'h00, "oor_read");
        checkOutput("oor_const", bus_c.data_o, 8'h00);
        for (int i = 0; i < 12; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, 4'(i), 8'h00, 8'h00, "oor_neighbours");

        $display("[TB] asynchronous reset mid-stream");
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd5, 8'h00, 8'h00, "pre_reset_read");
        #2 reset_ni = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) exp_m[k] = 8'h00;
        checkAll("async_reset");
        for (int i = 0; i < 3; i++) applyRandom(1'b0, "reset_random");
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd3, 8'h00, 8'h00, "post_reset_read");
        checkOutput("post_reset_const", bus_a.data_o, 8'h7A);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 300; i++) applyRandom(1'b1, "random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
